// File: rtl/lc3_sign_extender.sv
// lc3_sign_extender: widens an LC-3 immediate/offset field to the data word,
// with a combinational result and a load-captured registered copy.
module lc3_sign_extender #(
   parameter int unsigned IN_WIDTH  = 5,
   parameter int unsigned OUT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IN_WIDTH-1:0]  in,
   input  logic                 zext,
   output logic [OUT_WIDTH-1:0] out,
   input  logic                 load,
   output logic [OUT_WIDTH-1:0] out_q,
   output logic                 out_q_valid
);

   // Reject field widths that cannot be extended into the output word.
   generate
      if (IN_WIDTH < 1 || IN_WIDTH > OUT_WIDTH) begin : g_bad_width
         $error("lc3_sign_extender: IN_WIDTH must be in 1..OUT_WIDTH");
      end
   endgenerate

   // Full-width field needs no padding; otherwise replicate the fill bit.
   generate
      if (IN_WIDTH == OUT_WIDTH) begin : g_no_pad
         logic unused_zext;
         assign unused_zext = zext;
         assign out = in;
      end else begin : g_pad
         localparam int unsigned PAD_WIDTH = OUT_WIDTH - IN_WIDTH;
         logic fill;
         // Fill bit is the field's MSB in sign mode, zero in zero mode.
         always_comb begin
            fill = ~zext & in[IN_WIDTH-1];
            out  = {{PAD_WIDTH{fill}}, in};
         end
      end
   endgenerate

   // Capture the extended value on load; valid is sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_q_valid <= 1'b0;
      end else if (load) begin
         out_q       <= out;
         out_q_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lc3_sign_extender.sv
// Bench for lc3_sign_extender: several field widths side by side, directed
// cases followed by random traffic against an arithmetic reference model.
module tb_lc3_sign_extender;

   localparam int unsigned NI = 7;

   logic clk;
   logic rst_n;
   logic zext;
   logic load;

   logic [0:0]  in1;
   logic [3:0]  in4;
   logic [4:0]  in5;
   logic [5:0]  in6;
   logic [7:0]  in8;
   logic [14:0] in15;
   logic [15:0] in16;

   logic [15:0] o [NI];
   logic [15:0] q [NI];
   logic        v [NI];

   int widths [NI] = '{1, 4, 5, 6, 8, 15, 16};

   int n_checks = 0;
   int n_fail   = 0;

   lc3_sign_extender #(.IN_WIDTH(1),  .OUT_WIDTH(16)) u_w1  (.clk(clk), .rst_n(rst_n), .in(in1),  .zext(zext), .out(o[0]), .load(load), .out_q(q[0]), .out_q_valid(v[0]));
   lc3_sign_extender #(.IN_WIDTH(4),  .OUT_WIDTH(16)) u_w4  (.clk(clk), .rst_n(rst_n), .in(in4),  .zext(zext), .out(o[1]), .load(load), .out_q(q[1]), .out_q_valid(v[1]));
   lc3_sign_extender #(.IN_WIDTH(5),  .OUT_WIDTH(16)) u_w5  (.clk(clk), .rst_n(rst_n), .in(in5),  .zext(zext), .out(o[2]), .load(load), .out_q(q[2]), .out_q_valid(v[2]));
   lc3_sign_extender #(.IN_WIDTH(6),  .OUT_WIDTH(16)) u_w6  (.clk(clk), .rst_n(rst_n), .in(in6),  .zext(zext), .out(o[3]), .load(load), .out_q(q[3]), .out_q_valid(v[3]));
   lc3_sign_extender #(.IN_WIDTH(8),  .OUT_WIDTH(16)) u_w8  (.clk(clk), .rst_n(rst_n), .in(in8),  .zext(zext), .out(o[4]), .load(load), .out_q(q[4]), .out_q_valid(v[4]));
   lc3_sign_extender #(.IN_WIDTH(15), .OUT_WIDTH(16)) u_w15 (.clk(clk), .rst_n(rst_n), .in(in15), .zext(zext), .out(o[5]), .load(load), .out_q(q[5]), .out_q_valid(v[5]));
   lc3_sign_extender #(.IN_WIDTH(16), .OUT_WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .in(in16), .zext(zext), .out(o[6]), .load(load), .out_q(q[6]), .out_q_valid(v[6]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: interpret the field as two's complement (sign mode) or
   // unsigned (zero mode), then reduce the integer modulo 2^16.
   function automatic logic [15:0] ref_ext(input int w, input longint val, input bit z);
      longint r;
      r = val;
      if (!z && val >= (longint'(1) << (w - 1)))
         r = val - (longint'(1) << w);
      return 16'(r);
   endfunction

   function automatic longint field(input int k);
      case (k)
         0:       return longint'(in1);
         1:       return longint'(in4);
         2:       return longint'(in5);
         3:       return longint'(in6);
         4:       return longint'(in8);
         5:       return longint'(in15);
         default: return longint'(in16);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   logic [15:0] exp_q [NI];
   logic        exp_v;

   initial begin
      rst_n = 1'b0;
      load  = 1'b0;
      zext  = 1'b0;
      in1 = '0; in4 = '0; in5 = '0; in6 = '0; in8 = '0; in15 = '0; in16 = '0;
      #1;
      chk("reset_out_q",   q[3], 16'h0000);
      chk("reset_valid",   16'(v[3]), 16'h0000);

      // Combinational path, including during reset.
      in6 = 6'b111010; #1;
      chk("out_during_reset_w6", o[3], 16'hFFFA);
      in4 = 4'b1010; #1;
      chk("sext_w4", o[1], 16'hFFFA);
      in5 = 5'b01010; #1;
      chk("sext_w5", o[2], 16'h000A);
      in15 = 15'b011111010101010; #1;
      chk("sext_w15", o[5], 16'h3EAA);
      in5 = 5'b10000; #1;
      chk("w5_min", o[2], 16'hFFF0);
      in5 = 5'b01111; #1;
      chk("w5_max", o[2], 16'h000F);
      in5 = 5'b11111; #1;
      chk("w5_ones", o[2], 16'hFFFF);
      in5 = 5'b00000; #1;
      chk("w5_zero", o[2], 16'h0000);
      in8 = 8'hF5; zext = 1'b1; #1;
      chk("zext_w8", o[4], 16'h00F5);
      zext = 1'b0; #1;
      chk("sext_w8", o[4], 16'hFFF5);
      in16 = 16'h8001; #1;
      chk("w16_sext", o[6], 16'h8001);
      zext = 1'b1; #1;
      chk("w16_zext", o[6], 16'h8001);
      in1 = 1'b1; zext = 1'b0; #1;
      chk("w1_sext_one", o[0], 16'hFFFF);
      zext = 1'b1; #1;
      chk("w1_zext_one", o[0], 16'h0001);
      in1 = 1'b0; zext = 1'b0; #1;
      chk("w1_sext_zero", o[0], 16'h0000);

      // Release reset away from the clock edge.
      @(negedge clk);
      rst_n = 1'b1;

      // Registered path: load, then hold.
      @(negedge clk);
      in6 = 6'b111010; load = 1'b1;
      @(posedge clk); #1;
      chk("load_out_q", q[3], 16'hFFFA);
      chk("load_valid", 16'(v[3]), 16'h0001);
      @(negedge clk);
      load = 1'b0; in6 = 6'b000101; #1;
      chk("hold_out_follows", o[3], 16'h0005);
      @(posedge clk); #1;
      chk("hold_out_q", q[3], 16'hFFFA);
      chk("hold_valid", 16'(v[3]), 16'h0001);

      // Asynchronous reset between edges, with load held high.
      @(negedge clk);
      #2;
      rst_n = 1'b0; load = 1'b1; in6 = 6'b111010;
      #1;
      chk("async_rst_out_q", q[3], 16'h0000);
      chk("async_rst_valid", 16'(v[3]), 16'h0000);
      @(posedge clk); #1;
      chk("rst_blocks_load_q", q[3], 16'h0000);
      chk("rst_blocks_load_v", 16'(v[3]), 16'h0000);
      chk("rst_out_tracks", o[3], 16'hFFFA);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("first_edge_capture", q[3], 16'hFFFA);
      chk("first_edge_valid", 16'(v[3]), 16'h0001);

      // Random traffic across all widths against the reference model.
      for (int k = 0; k < int'(NI); k++) exp_q[k] = ref_ext(widths[k], field(k), zext);
      exp_v = 1'b1;
      for (int it = 0; it < 300; it++) begin
         @(negedge clk);
         in1  = 1'($urandom);
         in4  = 4'($urandom);
         in5  = 5'($urandom);
         in6  = 6'($urandom);
         in8  = 8'($urandom);
         in15 = 15'($urandom);
         in16 = 16'($urandom);
         zext = 1'($urandom);
         load = ($urandom_range(0, 2) != 0);
         if (it == 150) rst_n = 1'b0;
         if (it == 152) rst_n = 1'b1;
         #1;
         for (int k = 0; k < int'(NI); k++) begin
            chk($sformatf("rand_out_w%0d_%0d", widths[k], it), o[k], ref_ext(widths[k], field(k), zext));
            if (!rst_n) exp_q[k] = 16'h0000;
         end
         if (!rst_n) exp_v = 1'b0;
         if (rst_n && load) begin
            for (int k = 0; k < int'(NI); k++) exp_q[k] = ref_ext(widths[k], field(k), zext);
            exp_v = 1'b1;
         end
         @(posedge clk); #1;
         for (int k = 0; k < int'(NI); k++) begin
            chk($sformatf("rand_q_w%0d_%0d", widths[k], it), q[k], exp_q[k]);
            chk($sformatf("rand_v_w%0d_%0d", widths[k], it), 16'(v[k]), 16'(exp_v));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
